puf_round_sequencer: RTL and testbench

Parametrised successor to the single-shot PUF controller. It sequences one or more challenge rounds through the LFSR scrambler and, in reconstruct mode, the ECC decoder. It adds a per-round seed offset, per-stage timeout watchdogs, ECC-failure capture and an error/status interface. It sits between the security-engine command decoder and the scrambler/ECC datapath, and drives the same mux and stage-control signals.

---
 rtl/puf_round_sequencer_if.sv | 34 +++
 rtl/puf_round_sequencer.sv | 93 +++++++++
 tb/tb_puf_round_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/puf_round_sequencer_if.sv
// puf_round_sequencer_if: command, datapath-handshake and stage-control bundle
interface puf_round_sequencer_if #(
  parameter int SEED_WIDTH = 8,
  parameter int RND_WIDTH  = 4
);
  logic                  PUF_Go;
  logic [1:0]            Op_Type;
  logic [SEED_WIDTH-1:0] Challenge_Seed;
  logic [RND_WIDTH-1:0]  Round_Cnt;
  logic                  done_Scrambler;
  logic                  done_ECC_Dec;
  logic                  ECC_Fail;
  logic                  PUF_Busy;
  logic                  PUF_Done;
  logic                  PUF_Err;
  logic [2:0]            Err_Code;
  logic [RND_WIDTH-1:0]  Round_Idx;
  logic                  mux1_sel;
  logic                  En_Scrambler;
  logic                  Reset_Scrambler;
  logic [SEED_WIDTH-1:0] Seed_Data_LFSR;
  logic                  En_ECC_Dec;
  logic                  Reset_ECC_Dec;
  modport master (
    output PUF_Go, Op_Type, Challenge_Seed, Round_Cnt, done_Scrambler, done_ECC_Dec, ECC_Fail,
    input  PUF_Busy, PUF_Done, PUF_Err, Err_Code, Round_Idx, mux1_sel, En_Scrambler,
           Reset_Scrambler, Seed_Data_LFSR, En_ECC_Dec, Reset_ECC_Dec
  );
  modport slave (
    input  PUF_Go, Op_Type, Challenge_Seed, Round_Cnt, done_Scrambler, done_ECC_Dec, ECC_Fail,
    output PUF_Busy, PUF_Done, PUF_Err, Err_Code, Round_Idx, mux1_sel, En_Scrambler,
           Reset_Scrambler, Seed_Data_LFSR, En_ECC_Dec, Reset_ECC_Dec
  );
endinterface

// File: rtl/puf_round_sequencer.sv
// puf_round_sequencer: multi-round PUF scrambler/ECC sequencer with watchdogs and error reporting
module puf_round_sequencer #(
  parameter int SEED_WIDTH  = 8,
  parameter int RND_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic clk,
  input logic Reset,
  puf_round_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  typedef enum logic [2:0] {IDLE, LOAD, SCRAMBLE, ECC_RST, ECC_RUN, NEXT, FINISH, ERROR} state_t;
  state_t                state, state_nxt;
  logic [1:0]            op_q;
  logic [SEED_WIDTH-1:0] base_q, lfsr_seed;
  logic [RND_WIDTH-1:0]  count_q, round_idx, eff_cnt;
  logic [TW-1:0]         tmr;
  logic [2:0]            err_code, code_nxt;
  logic                  last, tmo;
  assign eff_cnt = bus.Op_Type[1] ? bus.Round_Cnt : RND_WIDTH'(1);
  assign last    = round_idx == count_q - RND_WIDTH'(1);
  assign tmo     = tmr == TW'(TIMEOUT_CYC - 1);
  // state register
  always_ff @(posedge clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nxt;
  // next state and error code; a done in the timeout cycle takes priority
  always_comb begin
    state_nxt = state;
    code_nxt  = err_code;
    case (state)
      IDLE: if (bus.PUF_Go) begin
        code_nxt  = eff_cnt == '0 ? 3'b100 : 3'b000;
        state_nxt = eff_cnt == '0 ? ERROR : LOAD;
      end
      LOAD:     state_nxt = SCRAMBLE;
      SCRAMBLE: if (bus.done_Scrambler) state_nxt = op_q[0] ? ECC_RST : NEXT;
                else if (tmo) begin
                  state_nxt = ERROR;
                  code_nxt  = 3'b001;
                end
      ECC_RST:  state_nxt = ECC_RUN;
      ECC_RUN:  if (bus.done_ECC_Dec) begin
                  state_nxt = bus.ECC_Fail ? ERROR : NEXT;
                  code_nxt  = bus.ECC_Fail ? 3'b011 : err_code;
                end else if (tmo) begin
                  state_nxt = ERROR;
                  code_nxt  = 3'b010;
                end
      NEXT:     state_nxt = last ? FINISH : LOAD;
      default:  state_nxt = IDLE;
    endcase
  end
  // operation context, round index, per-round seed and stage watchdog
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      op_q      <= '0;
      base_q    <= '0;
      count_q   <= '0;
      round_idx <= '0;
      lfsr_seed <= '0;
      tmr       <= '0;
      err_code  <= '0;
    end else begin
      err_code <= code_nxt;
      tmr      <= (state == LOAD || state == ECC_RST) ? '0 :
                  (state == SCRAMBLE || state == ECC_RUN) ? tmr + TW'(1) : tmr;
      if (state == IDLE && bus.PUF_Go) begin
        op_q      <= bus.Op_Type;
        base_q    <= bus.Challenge_Seed;
        count_q   <= eff_cnt;
        round_idx <= '0;
      end
      if (state == NEXT && !last) round_idx <= round_idx + RND_WIDTH'(1);
      if (state_nxt == LOAD)
        lfsr_seed <= state == IDLE ? bus.Challenge_Seed
                                   : base_q + SEED_WIDTH'(round_idx) + SEED_WIDTH'(1);
    end
  // outputs decoded from the state register or taken straight from registers
  always_comb begin
    bus.PUF_Busy        = state != IDLE;
    bus.PUF_Done        = state == FINISH || state == ERROR;
    bus.PUF_Err         = state == ERROR;
    bus.Err_Code        = err_code;
    bus.Round_Idx       = round_idx;
    bus.mux1_sel        = op_q[0];
    bus.En_Scrambler    = state == LOAD || state == SCRAMBLE;
    bus.Reset_Scrambler = state == LOAD;
    bus.Seed_Data_LFSR  = lfsr_seed;
    bus.En_ECC_Dec      = state == ECC_RST || state == ECC_RUN;
    bus.Reset_ECC_Dec   = state == ECC_RST;
  end
endmodule

// File: tb/tb_puf_round_sequencer.sv
// tb_puf_round_sequencer: scoreboard bench for the PUF round sequencer
module tb_puf_round_sequencer;
  logic clk = 0;
  logic rst = 1;
  puf_round_sequencer_if #(.SEED_WIDTH(8), .RND_WIDTH(4)) bus();
  puf_round_sequencer #(.SEED_WIDTH(8), .RND_WIDTH(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .Reset(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       err;
    logic [2:0] code;
    logic [3:0] idx;
    logic       mux;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] seed_q[$];
  int n_chk = 0, n_fail = 0;
  int n_rs = 0, n_re = 0, n_ee = 0, n_done = 0;
  int s_lat = 0, e_lat = 0, sc = 0, ec = 0;
  logic e_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // datapath responder: raises done after a programmed number of wait-state cycles
  always @(posedge clk) begin
    #1;
    sc = (bus.En_Scrambler && !bus.Reset_Scrambler) ? sc + 1 : 0;
    ec = (bus.En_ECC_Dec && !bus.Reset_ECC_Dec) ? ec + 1 : 0;
    bus.done_Scrambler = s_lat > 0 && sc == s_lat;
    bus.done_ECC_Dec   = e_lat > 0 && ec == e_lat;
    bus.ECC_Fail       = e_fail && bus.done_ECC_Dec;
  end
  // monitor: seeds checked on each scrambler reset, results checked on each done
  always @(negedge clk) if (!rst) begin
    if (bus.Reset_Scrambler) begin
      n_rs++;
      chk("seed_avail", seed_q.size() > 0, 1);
      if (seed_q.size() > 0) chk("seed", bus.Seed_Data_LFSR, seed_q.pop_front());
    end
    if (bus.Reset_ECC_Dec) n_re++;
    if (bus.En_ECC_Dec) n_ee++;
    if (bus.PUF_Err) chk("err_with_done", bus.PUF_Done, 1);
    if (bus.PUF_Done) begin
      exp_t e;
      n_done++;
      chk("done_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("err", bus.PUF_Err, e.err);
        chk("code", bus.Err_Code, e.code);
        chk("idx", bus.Round_Idx, e.idx);
        chk("mux", bus.mux1_sel, e.mux);
      end
    end
  end
  task automatic expect_res(input logic err, input logic [2:0] code, input logic [3:0] idx, input logic mux);
    exp_t e;
    e.err = err; e.code = code; e.idx = idx; e.mux = mux;
    exp_q.push_back(e);
  endtask
  task automatic go(input logic [1:0] op, input logic [7:0] seed, input logic [3:0] cnt,
                    input int sl, input int el, input logic fl, output int lat);
    s_lat = sl; e_lat = el; e_fail = fl;
    n_rs = 0; n_re = 0; n_ee = 0; n_done = 0;
    @(posedge clk); #1;
    bus.Op_Type = op; bus.Challenge_Seed = seed; bus.Round_Cnt = cnt; bus.PUF_Go = 1;
    @(posedge clk); #1;
    bus.PUF_Go = 0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.PUF_Done === 1'b1) break;
      if (lat >= 300) begin
        chk("done_seen", bus.PUF_Done, 1);
        break;
      end
    end
    @(negedge clk);
    chk("busy_falls", bus.PUF_Busy, 0);
  endtask
  initial begin
    int lat;
    bus.PUF_Go = 0; bus.Op_Type = 0; bus.Challenge_Seed = 0; bus.Round_Cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", bus.PUF_Busy, 0);
    chk("rst_done", bus.PUF_Done, 0);
    chk("rst_en_scr", bus.En_Scrambler, 0);
    chk("rst_seed", bus.Seed_Data_LFSR, 0);
    chk("rst_code", bus.Err_Code, 0);
    chk("rst_mux", bus.mux1_sel, 0);
    // single-round enroll, done three cycles into SCRAMBLE
    seed_q.push_back(8'h5A); expect_res(0, 3'b000, 0, 0);
    go(2'b00, 8'h5A, 4'd7, 3, 0, 0, lat);
    chk("enroll_lat", lat, 6);
    chk("enroll_no_ecc", n_ee, 0);
    chk("enroll_ndone", n_done, 1);
    // minimum-latency enroll
    seed_q.push_back(8'h11); expect_res(0, 3'b000, 0, 0);
    go(2'b00, 8'h11, 4'd0, 1, 0, 0, lat);
    chk("min_lat", lat, 4);
    // three-round reconstruct with seed wrap
    seed_q.push_back(8'hFE); seed_q.push_back(8'hFF); seed_q.push_back(8'h00);
    expect_res(0, 3'b000, 2, 1);
    go(2'b11, 8'hFE, 4'd3, 2, 2, 0, lat);
    chk("multi_lat", lat, 22);
    chk("multi_rs", n_rs, 3);
    chk("multi_re", n_re, 3);
    chk("multi_ndone", n_done, 1);
    // uncorrectable ECC
    seed_q.push_back(8'h33); expect_res(1, 3'b011, 0, 1);
    go(2'b01, 8'h33, 4'd0, 1, 1, 1, lat);
    chk("eccfail_lat", lat, 5);
    chk("code_hold", bus.Err_Code, 3'b011);
    // scrambler timeout
    seed_q.push_back(8'h10); expect_res(1, 3'b001, 0, 0);
    go(2'b00, 8'h10, 4'd0, 0, 0, 0, lat);
    chk("scr_tmo_lat", lat, 18);
    // done coincident with the timeout cycle wins
    seed_q.push_back(8'h20); expect_res(0, 3'b000, 0, 0);
    go(2'b00, 8'h20, 4'd0, 16, 0, 0, lat);
    chk("tmo_edge_lat", lat, 19);
    // ECC timeout
    seed_q.push_back(8'h30); expect_res(1, 3'b010, 0, 1);
    go(2'b01, 8'h30, 4'd0, 1, 0, 0, lat);
    chk("ecc_tmo_lat", lat, 20);
    // zero round count, then recovery clears the code
    expect_res(1, 3'b100, 0, 0);
    go(2'b10, 8'h40, 4'd0, 1, 0, 0, lat);
    chk("zero_lat", lat, 1);
    chk("zero_no_scr", n_rs, 0);
    seed_q.push_back(8'h41); expect_res(0, 3'b000, 0, 0);
    go(2'b10, 8'h41, 4'd1, 1, 0, 0, lat);
    chk("one_lat", lat, 4);
    // busy-time Go ignored, asynchronous reset in ECC_RUN abandons the operation
    s_lat = 1; e_lat = 0; e_fail = 0; n_done = 0;
    seed_q.push_back(8'h44);
    @(posedge clk); #1;
    bus.Op_Type = 2'b01; bus.Challenge_Seed = 8'h44; bus.PUF_Go = 1;
    @(posedge clk); #1;
    bus.PUF_Go = 0;
    @(posedge clk); #1;
    bus.Op_Type = 2'b00; bus.Challenge_Seed = 8'h99; bus.PUF_Go = 1;
    @(posedge clk); #1;
    bus.PUF_Go = 0;
    for (int i = 0; i < 20 && !(bus.En_ECC_Dec && !bus.Reset_ECC_Dec); i++) @(negedge clk);
    chk("in_ecc_run", bus.En_ECC_Dec && !bus.Reset_ECC_Dec, 1);
    chk("busy_go_mux", bus.mux1_sel, 1);
    chk("busy_go_seed", bus.Seed_Data_LFSR, 8'h44);
    #2 rst = 1;
    #1;
    chk("arst_busy", bus.PUF_Busy, 0);
    chk("arst_en_ecc", bus.En_ECC_Dec, 0);
    chk("arst_mux", bus.mux1_sel, 0);
    chk("arst_seed", bus.Seed_Data_LFSR, 0);
    chk("arst_done", bus.PUF_Done, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", bus.PUF_Busy, 0);
    chk("post_rst_ndone", n_done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
